// File: rtl/err_inject_ctrl.sv
// Error injector: delays, then corrupts a burst of registered data cycles with stuck-at/flip masks.
// Latency: dout is din registered by one cycle; corruption applies on cycles where inj_active is high.
// Backpressure: none; arm is ignored unless idle and enabled, and err_en low aborts any sequence.
module err_inject_ctrl #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8,
    parameter int EVT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             err_en,
    input  logic [1:0]       err_ctrl,
    input  logic [WIDTH-1:0] err_mask,
    input  logic             arm,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] burst,
    input  logic             clr_cnt,
    output logic             busy,
    output logic             inj_active,
    output logic             inj_done,
    output logic [EVT_W-1:0] inj_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_INJECT,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_cfg;
    logic [1:0]       ctrl_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] burst_q;
    logic [WIDTH-1:0] corrupt;

    // One counter serves both phases: it holds the remaining delay in WAIT and
    // the remaining burst length in INJECT (unused when burst is continuous).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_cfg  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm && err_en) begin
                    load_cfg = 1'b1;
                    if (delay == '0) begin
                        state_nxt = ST_INJECT;
                        cnt_nxt   = burst;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = delay;
                    end
                end
            end
            ST_WAIT: begin
                if (!err_en) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_INJECT;
                    cnt_nxt   = burst_q;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_INJECT: begin
                if (!err_en) begin
                    state_nxt = ST_IDLE;
                end else if (burst_q != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ctrl_q  <= '0;
            mask_q  <= '0;
            burst_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_cfg) begin
                ctrl_q  <= err_ctrl;
                mask_q  <= err_mask;
                burst_q <= burst;
            end
        end
    end

    always_comb begin
        case (ctrl_q)
            2'b01:   corrupt = din & ~mask_q;
            2'b10:   corrupt = din | mask_q;
            2'b11:   corrupt = din ^ mask_q;
            default: corrupt = din;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout      <= '0;
            inj_count <= '0;
        end else begin
            dout <= inj_active ? corrupt : din;
            if (clr_cnt) begin
                inj_count <= '0;
            end else if (inj_active && (inj_count != '1)) begin
                inj_count <= inj_count + EVT_W'(1);
            end
        end
    end

    assign busy       = (state != ST_IDLE);
    assign inj_active = (state == ST_INJECT);
    assign inj_done   = (state == ST_DONE);

endmodule

// File: tb/tb_err_inject_ctrl.sv
module tb_err_inject_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  din;
    logic [5:0]  dout, dout4;
    logic        err_en;
    logic [1:0]  err_ctrl;
    logic [5:0]  err_mask;
    logic        arm;
    logic [7:0]  delay;
    logic [7:0]  burst;
    logic        clr_cnt;
    logic        busy, busy4;
    logic        inj_active, inj_active4;
    logic        inj_done, inj_done4;
    logic [15:0] inj_count;
    logic [3:0]  inj_count4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    err_inject_ctrl dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout), .err_en(err_en),
        .err_ctrl(err_ctrl), .err_mask(err_mask), .arm(arm), .delay(delay),
        .burst(burst), .clr_cnt(clr_cnt), .busy(busy), .inj_active(inj_active),
        .inj_done(inj_done), .inj_count(inj_count)
    );

    err_inject_ctrl #(.EVT_W(4)) dut4 (
        .clk(clk), .rst(rst), .din(din), .dout(dout4), .err_en(err_en),
        .err_ctrl(err_ctrl), .err_mask(err_mask), .arm(arm), .delay(delay),
        .burst(burst), .clr_cnt(clr_cnt), .busy(busy4), .inj_active(inj_active4),
        .inj_done(inj_done4), .inj_count(inj_count4)
    );

    typedef struct {
        logic [1:0] ctrl;
        logic [5:0] mask;
        logic [5:0] din;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_count();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b01, 6'h3F, 6'h15, 6'h00};
        vecs[1] = '{2'b10, 6'h3F, 6'h15, 6'h3F};
        vecs[2] = '{2'b11, 6'h0F, 6'h2A, 6'h25};
        vecs[3] = '{2'b00, 6'h3F, 6'h15, 6'h15};
        vecs[4] = '{2'b01, 6'h30, 6'h3C, 6'h0C};
        vecs[5] = '{2'b10, 6'h03, 6'h20, 6'h23};

        rst = 1'b1; din = '0; err_en = 1'b0; err_ctrl = '0; err_mask = '0;
        arm = 1'b0; delay = '0; burst = '0; clr_cnt = 1'b0;
        step();
        step();
        chk("reset_dout", dout, 0);
        chk("reset_busy", busy, 0);
        chk("reset_active", inj_active, 0);
        chk("reset_done", inj_done, 0);
        chk("reset_count", inj_count, 0);
        rst = 1'b0;

        // Pass-through: arm with err_en low is ignored
        din = 6'h2A; arm = 1'b1; err_ctrl = 2'b11; err_mask = 6'h3F;
        step();
        arm = 1'b0;
        chk("pass_dout", dout, 6'h2A);
        chk("pass_busy", busy, 0);
        step();
        chk("pass_count", inj_count, 0);

        // Single-cycle corruption vectors, delay=0 burst=1
        err_en = 1'b1; delay = 8'd0; burst = 8'd1;
        for (int i = 0; i < 6; i++) begin
            err_ctrl = vecs[i].ctrl; err_mask = vecs[i].mask; din = vecs[i].din;
            arm = 1'b1;
            step();
            arm = 1'b0;
            chk($sformatf("vec%0d_active", i), inj_active, 1);
            step();
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp);
            chk($sformatf("vec%0d_done", i), inj_done, 1);
            step();
            chk($sformatf("vec%0d_after", i), dout, vecs[i].din);
        end

        // Flip: delay=2 burst=3, config changed and arm re-pulsed while running
        clear_count();
        err_ctrl = 2'b11; err_mask = 6'h0F; delay = 8'd2; burst = 8'd3; din = 6'h2A;
        arm = 1'b1;
        step();
        arm = 1'b0;
        err_ctrl = 2'b01; err_mask = 6'h3F; delay = 8'd9; burst = 8'd9;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("flip_active_T%0d", k), inj_active, (k >= 3 && k <= 5));
            chk($sformatf("flip_dout_T%0d", k), dout, (k >= 4 && k <= 6) ? 6'h25 : 6'h2A);
            chk($sformatf("flip_done_T%0d", k), inj_done, (k == 6));
            chk($sformatf("flip_busy_T%0d", k), busy, (k <= 6));
            arm = (k == 1 || k == 5);
            step();
            arm = 1'b0;
        end
        chk("flip_count", inj_count, 3);

        // Abort continuous burst after 5 INJECT cycles
        clear_count();
        err_ctrl = 2'b11; err_mask = 6'h01; delay = 8'd0; burst = 8'd0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 1; k < 5; k++) step();
        chk("abort_active_T5", inj_active, 1);
        err_en = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_done", inj_done, 0);
        chk("abort_count", inj_count, 5);
        step();
        chk("abort_done_late", inj_done, 0);

        // Saturation on the narrow counter, then clear-vs-increment priority
        clear_count();
        err_en = 1'b1; delay = 8'd0; burst = 8'd20;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 1; k < 16; k++) step();
        chk("sat_count16", inj_count4, 15);
        for (int k = 16; k < 21; k++) step();
        chk("sat_done", inj_done4, 1);
        chk("sat_count_hold", inj_count4, 15);
        chk("sat_count_wide", inj_count, 20);
        step();
        burst = 8'd0; arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        clr_cnt = 1'b1;
        chk("clr_in_inject", inj_active4, 1);
        step();
        clr_cnt = 1'b0;
        chk("clr_count", inj_count4, 0);
        step();
        chk("clr_resume", inj_count4, 1);
        err_en = 1'b0;
        step();
        chk("clr_idle", busy4, 0);

        // Reset mid-WAIT
        err_en = 1'b1; delay = 8'd10; burst = 8'd2; err_ctrl = 2'b10; err_mask = 6'h3F;
        din = 6'h00;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 1; k < 4; k++) step();
        chk("rstw_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_active", inj_active, 0);
        chk("rstw_done", inj_done, 0);
        chk("rstw_count", inj_count, 0);
        chk("rstw_dout", dout, 0);
        step();
        rst = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 12; k++) begin
                if (inj_active) seen++;
                step();
            end
            chk("rstw_no_inject", seen, 0);
        end
        delay = 8'd0; burst = 8'd1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("rstw_rearm_active", inj_active, 1);
        step();
        chk("rstw_rearm_dout", dout, 6'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
